// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM for the multicycle RV32I core.
// Sequences the shared ALU, memory, register file and immediate unit.
// Supported instructions are lw, sw, R-ALU, I-ALU, beq/bne, jal and lui.
// Every other opcode is flagged illegal and executed as a nop.
// Optional feature: define MULTICYCLE_MEM_WAIT_EN so FETCH, MEMREAD and
// MEMWRITE hold until i_mem_ready is high.
module multicycle_ctrl #(
    parameter int FETCH_INC = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_instr,
    input  logic        i_zero,
    input  logic        i_mem_ready,
    output logic        o_pc_write,
    output logic        o_adr_src,
    output logic        o_mem_write,
    output logic        o_ir_write,
    output logic        o_reg_write,
    output logic [1:0]  o_result_src,
    output logic [1:0]  o_alu_src_a,
    output logic [1:0]  o_alu_src_b,
    output logic [2:0]  o_alu_control,
    output logic [2:0]  o_imm_src,
    output logic        o_illegal,
    output logic        o_retire,
    output logic [3:0]  o_state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        LUI      = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RALU   = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b101;
    localparam logic [2:0] IMM_U = 3'b010;
    localparam logic [2:0] IMM_J = 3'b110;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t      r_state;
    state_t      w_nextState;
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_funct7b5;
    logic        w_memReady;
    logic [31:0] w_unusedInc;
    logic        w_unused;

    assign w_opcode   = i_instr[6:0];
    assign w_funct3   = i_instr[14:12];
    assign w_funct7b5 = i_instr[30];

    // FETCH_INC only documents the constant the datapath supplies; these
    // fields and ports are deliberately left unconsumed here.
    assign w_unusedInc = FETCH_INC;
    assign w_unused    = &{1'b0, i_instr[31], i_instr[29:15], i_instr[11:7],
                           i_mem_ready, w_unusedInc};

`ifdef MULTICYCLE_MEM_WAIT_EN
    assign w_memReady = i_mem_ready;
`else
    assign w_memReady = 1'b1;
`endif

    // The debug state view reads zero for as long as reset is held.
    assign o_state = i_rst ? 4'd0 : r_state;

    // ALU operation shared by EXECR and EXECI; subBit selects sub for funct3=000.
    function automatic logic [2:0] aluFromFunct3(input logic [2:0] f3, input logic subBit);
        case (f3)
            3'b000:  aluFromFunct3 = subBit ? ALU_SUB : ALU_ADD;
            3'b010:  aluFromFunct3 = ALU_SLT;
            3'b110:  aluFromFunct3 = ALU_OR;
            3'b111:  aluFromFunct3 = ALU_AND;
            default: aluFromFunct3 = ALU_ADD;
        endcase
    endfunction

    // State register; reset returns to FETCH and aborts any instruction in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Per-state datapath controls and next state; everything is forced to 0 under reset.
    always_comb begin
        o_pc_write    = 1'b0;
        o_adr_src     = 1'b0;
        o_mem_write   = 1'b0;
        o_ir_write    = 1'b0;
        o_reg_write   = 1'b0;
        o_result_src  = 2'b00;
        o_alu_src_a   = 2'b00;
        o_alu_src_b   = 2'b00;
        o_alu_control = ALU_ADD;
        o_imm_src     = IMM_I;
        o_illegal     = 1'b0;
        o_retire      = 1'b0;
        w_nextState   = FETCH;
        if (!i_rst) begin
            case (r_state)
                DECODE: begin
                    o_alu_src_a = 2'b01;
                    o_alu_src_b = 2'b01;
                    if (w_opcode == OP_BRANCH) begin
                        o_imm_src = IMM_B;
                    end else if (w_opcode == OP_JAL) begin
                        o_imm_src = IMM_J;
                    end
                    case (w_opcode)
                        OP_LOAD, OP_STORE: w_nextState = MEMADR;
                        OP_RALU:           w_nextState = EXECR;
                        OP_IALU:           w_nextState = EXECI;
                        OP_BRANCH:         w_nextState = BRANCH;
                        OP_JAL:            w_nextState = JAL;
                        OP_LUI:            w_nextState = LUI;
                        default: begin
                            o_illegal   = 1'b1;
                            o_retire    = 1'b1;
                            w_nextState = FETCH;
                        end
                    endcase
                end
                MEMADR: begin
                    o_alu_src_a = 2'b10;
                    o_alu_src_b = 2'b01;
                    o_imm_src   = (w_opcode == OP_STORE) ? IMM_S : IMM_I;
                    w_nextState = (w_opcode == OP_STORE) ? MEMWRITE : MEMREAD;
                end
                MEMREAD: begin
                    o_adr_src    = 1'b1;
                    o_result_src = 2'b00;
                    w_nextState  = w_memReady ? MEMWB : MEMREAD;
                end
                MEMWB: begin
                    o_result_src = 2'b01;
                    o_reg_write  = 1'b1;
                    o_retire     = 1'b1;
                    w_nextState  = FETCH;
                end
                MEMWRITE: begin
                    o_adr_src   = 1'b1;
                    o_mem_write = w_memReady;
                    o_retire    = w_memReady;
                    w_nextState = w_memReady ? FETCH : MEMWRITE;
                end
                EXECR: begin
                    o_alu_src_a   = 2'b10;
                    o_alu_src_b   = 2'b00;
                    o_alu_control = aluFromFunct3(w_funct3, w_funct7b5);
                    w_nextState   = ALUWB;
                end
                EXECI: begin
                    o_alu_src_a   = 2'b10;
                    o_alu_src_b   = 2'b01;
                    o_imm_src     = IMM_I;
                    o_alu_control = aluFromFunct3(w_funct3, 1'b0);
                    w_nextState   = ALUWB;
                end
                ALUWB: begin
                    o_result_src = 2'b00;
                    o_reg_write  = 1'b1;
                    o_retire     = 1'b1;
                    w_nextState  = FETCH;
                end
                BRANCH: begin
                    o_alu_src_a   = 2'b10;
                    o_alu_src_b   = 2'b00;
                    o_alu_control = ALU_SUB;
                    o_result_src  = 2'b00;
                    o_retire      = 1'b1;
                    o_pc_write    = (w_funct3[2:1] == 2'b00) ? (i_zero ^ w_funct3[0]) : 1'b0;
                    w_nextState   = FETCH;
                end
                JAL: begin
                    o_alu_src_a  = 2'b01;
                    o_alu_src_b  = 2'b10;
                    o_result_src = 2'b00;
                    o_pc_write   = 1'b1;
                    o_imm_src    = IMM_J;
                    w_nextState  = ALUWB;
                end
                LUI: begin
                    o_alu_src_a = 2'b11;
                    o_alu_src_b = 2'b01;
                    o_imm_src   = IMM_U;
                    w_nextState = ALUWB;
                end
                default: begin
                    // FETCH, and any unreachable code, behaves as instruction fetch.
                    o_ir_write   = w_memReady;
                    o_pc_write   = w_memReady;
                    o_adr_src    = 1'b0;
                    o_alu_src_a  = 2'b00;
                    o_alu_src_b  = 2'b10;
                    o_result_src = 2'b10;
                    w_nextState  = w_memReady ? DECODE : FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed-vector bench for multicycle_ctrl with
// hand-computed expected control values per state.
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        zero;
    logic        memReady;
    logic        pcWrite;
    logic        adrSrc;
    logic        memWrite;
    logic        irWrite;
    logic        regWrite;
    logic [1:0]  resultSrc;
    logic [1:0]  aluSrcA;
    logic [1:0]  aluSrcB;
    logic [2:0]  aluControl;
    logic [2:0]  immSrc;
    logic        illegal;
    logic        retire;
    logic [3:0]  state;

    int assertCount = 0;
    int failCount   = 0;

    multicycle_ctrl #(.FETCH_INC(4)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_instr       (instr),
        .i_zero        (zero),
        .i_mem_ready   (memReady),
        .o_pc_write    (pcWrite),
        .o_adr_src     (adrSrc),
        .o_mem_write   (memWrite),
        .o_ir_write    (irWrite),
        .o_reg_write   (regWrite),
        .o_result_src  (resultSrc),
        .o_alu_src_a   (aluSrcA),
        .o_alu_src_b   (aluSrcB),
        .o_alu_control (aluControl),
        .o_imm_src     (immSrc),
        .o_illegal     (illegal),
        .o_retire      (retire),
        .o_state       (state)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the falling edge, far from the active edge.
    task automatic applyStimulus;
        @(negedge clk);
        #1;
    endtask

    // Drive the directed sequence and compare outputs against hand-derived values.
    initial begin
        rst      = 1'b1;
        instr    = 32'h0000_0000;
        zero     = 1'b0;
        memReady = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("rst_state", state, 4'd0);
        checkOutput("rst_ir_write", irWrite, 1'b0);
        checkOutput("rst_pc_write", pcWrite, 1'b0);
        checkOutput("rst_alu_src_b", aluSrcB, 2'b00);

        rst = 1'b0;
        #1;
        checkOutput("fetch_state", state, 4'd0);
        checkOutput("fetch_ir_write", irWrite, 1'b1);
        checkOutput("fetch_pc_write", pcWrite, 1'b1);
        checkOutput("fetch_alu_src_b", aluSrcB, 2'b10);
        checkOutput("fetch_result_src", resultSrc, 2'b10);

        // addi x1,x0,10 : 0,1,7,8
        instr = 32'h00A00093;
        applyStimulus;
        checkOutput("addi_decode_state", state, 4'd1);
        checkOutput("addi_decode_src_a", aluSrcA, 2'b01);
        checkOutput("addi_decode_src_b", aluSrcB, 2'b01);
        checkOutput("addi_decode_ir_write", irWrite, 1'b0);
        applyStimulus;
        checkOutput("addi_execi_state", state, 4'd7);
        checkOutput("addi_execi_imm", immSrc, 3'b000);
        checkOutput("addi_execi_alu", aluControl, 3'b000);
        checkOutput("addi_execi_src_a", aluSrcA, 2'b10);
        applyStimulus;
        checkOutput("addi_aluwb_state", state, 4'd8);
        checkOutput("addi_aluwb_reg_write", regWrite, 1'b1);
        checkOutput("addi_aluwb_retire", retire, 1'b1);
        applyStimulus;
        checkOutput("addi_back_fetch", state, 4'd0);

        // addi with imm bit 30 set must still add
        instr = 32'hC0008093;
        applyStimulus;
        applyStimulus;
        checkOutput("addi_neg_execi_state", state, 4'd7);
        checkOutput("addi_neg_execi_alu", aluControl, 3'b000);
        applyStimulus;
        applyStimulus;

        // sub x0,x1,x2 : EXECR with sub
        instr = 32'h40208033;
        applyStimulus;
        applyStimulus;
        checkOutput("sub_execr_state", state, 4'd6);
        checkOutput("sub_execr_alu", aluControl, 3'b001);
        checkOutput("sub_execr_src_b", aluSrcB, 2'b00);
        applyStimulus;
        checkOutput("sub_aluwb_state", state, 4'd8);
        applyStimulus;

        // sw : 0,1,2,5
        instr = 32'h0020A223;
        applyStimulus;
        checkOutput("sw_decode_state", state, 4'd1);
        applyStimulus;
        checkOutput("sw_memadr_state", state, 4'd2);
        checkOutput("sw_memadr_imm", immSrc, 3'b001);
        applyStimulus;
        checkOutput("sw_memwrite_state", state, 4'd5);
        checkOutput("sw_memwrite_we", memWrite, 1'b1);
        checkOutput("sw_memwrite_adr", adrSrc, 1'b1);
        checkOutput("sw_memwrite_retire", retire, 1'b1);
        applyStimulus;
        checkOutput("sw_back_fetch", state, 4'd0);

        // beq taken : 0,1,9
        instr = 32'h00208463;
        zero  = 1'b1;
        applyStimulus;
        checkOutput("beq_decode_imm", immSrc, 3'b101);
        applyStimulus;
        checkOutput("beq_branch_state", state, 4'd9);
        checkOutput("beq_taken_pc_write", pcWrite, 1'b1);
        checkOutput("beq_branch_alu", aluControl, 3'b001);
        checkOutput("beq_branch_retire", retire, 1'b1);
        applyStimulus;
        checkOutput("beq_back_fetch", state, 4'd0);

        // beq not taken
        zero = 1'b0;
        applyStimulus;
        applyStimulus;
        checkOutput("beq_nt_pc_write", pcWrite, 1'b0);
        applyStimulus;

        // bne taken with zero=0
        instr = 32'h00209463;
        applyStimulus;
        applyStimulus;
        checkOutput("bne_branch_state", state, 4'd9);
        checkOutput("bne_taken_pc_write", pcWrite, 1'b1);
        applyStimulus;

        // jal : 0,1,10,8
        instr = 32'h008000EF;
        applyStimulus;
        checkOutput("jal_decode_imm", immSrc, 3'b110);
        applyStimulus;
        checkOutput("jal_state", state, 4'd10);
        checkOutput("jal_pc_write", pcWrite, 1'b1);
        checkOutput("jal_src_a", aluSrcA, 2'b01);
        checkOutput("jal_src_b", aluSrcB, 2'b10);
        applyStimulus;
        checkOutput("jal_aluwb_state", state, 4'd8);
        applyStimulus;

        // illegal opcode : 0,1 then FETCH
        instr = 32'hFFFFFFFF;
        applyStimulus;
        checkOutput("illegal_decode_state", state, 4'd1);
        checkOutput("illegal_pulse", illegal, 1'b1);
        checkOutput("illegal_retire", retire, 1'b1);
        applyStimulus;
        checkOutput("illegal_back_fetch", state, 4'd0);
        checkOutput("illegal_pulse_cleared", illegal, 1'b0);

        // lw : 0,1,2,3,4
        instr = 32'h0000A083;
        applyStimulus;
        applyStimulus;
        checkOutput("lw_memadr_imm", immSrc, 3'b000);
        applyStimulus;
        checkOutput("lw_memread_state", state, 4'd3);
        checkOutput("lw_memread_adr", adrSrc, 1'b1);
`ifdef MULTICYCLE_MEM_WAIT_EN
        memReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus;
            checkOutput("lw_wait_hold_state", state, 4'd3);
            checkOutput("lw_wait_hold_adr", adrSrc, 1'b1);
        end
        memReady = 1'b1;
`endif
        applyStimulus;
        checkOutput("lw_memwb_state", state, 4'd4);
        checkOutput("lw_memwb_result", resultSrc, 2'b01);
        checkOutput("lw_memwb_reg_write", regWrite, 1'b1);
        applyStimulus;
        checkOutput("lw_back_fetch", state, 4'd0);

        // lw aborted by reset in MEMREAD
        applyStimulus;
        applyStimulus;
        applyStimulus;
        checkOutput("lwabort_memread_state", state, 4'd3);
        rst = 1'b1;
        #1;
        checkOutput("lwabort_rst_state", state, 4'd0);
        checkOutput("lwabort_rst_reg_write", regWrite, 1'b0);
        checkOutput("lwabort_rst_adr", adrSrc, 1'b0);
        applyStimulus;
        checkOutput("lwabort_held_reg_write", regWrite, 1'b0);
        instr = 32'h12345037;
        rst   = 1'b0;
        #1;
        checkOutput("lwabort_after_state", state, 4'd0);
        checkOutput("lwabort_after_ir_write", irWrite, 1'b1);
        checkOutput("lwabort_after_reg_write", regWrite, 1'b0);

        // lui : 0,1,11,8
        applyStimulus;
        applyStimulus;
        checkOutput("lui_state", state, 4'd11);
        checkOutput("lui_src_a", aluSrcA, 2'b11);
        checkOutput("lui_imm", immSrc, 3'b010);
        applyStimulus;
        checkOutput("lui_aluwb_reg_write", regWrite, 1'b1);
        applyStimulus;

`ifndef MULTICYCLE_MEM_WAIT_EN
        // Without the wait feature, mem_ready low must not stall FETCH
        memReady = 1'b0;
        checkOutput("noWait_fetch_ir_write", irWrite, 1'b1);
        applyStimulus;
        checkOutput("noWait_decode_state", state, 4'd1);
        memReady = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
